// File: rtl/sprite_compositor.sv
// Sprite compositor: per-layer ROM addressing, colour-key priority merge with
// saturating fade, and a PLAY/DYING/OVER death-animation controller.

module sprite_layer (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  org_x,
  input  logic [9:0]  org_y,
  input  logic [2:0]  shift,
  input  logic [2:0]  frame,
  output logic [18:0] addr
);
  logic [9:0]  dx, dy;
  logic [2:0]  sh;
  logic [15:0] loc;

  assign dx  = draw_x - org_x;
  assign dy  = draw_y - org_y;
  // Sprites are at most 64 wide; larger shift codes clamp.
  assign sh  = (shift > 3'd6) ? 3'd6 : shift;
  assign loc = {6'd0, dx} + ({6'd0, dy} << sh);

  always_ff @(posedge clk) begin
    if (reset) addr <= '0;
    else       addr <= {frame, loc};
  end
endmodule

module sprite_compositor #(
  parameter int          N_LAYERS    = 4,
  parameter int          ROM_LAT     = 2,
  parameter logic [23:0] KEY         = 24'hFF0000,
  parameter logic [23:0] BG          = 24'hB7FE7B,
  parameter int          ANIM_STEPS  = 5,
  parameter int          ANIM_PERIOD = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [N_LAYERS-1:0]     layer_hit,
  input  logic [10*N_LAYERS-1:0]  layer_x,
  input  logic [10*N_LAYERS-1:0]  layer_y,
  input  logic [3*N_LAYERS-1:0]   layer_shift,
  input  logic [2*N_LAYERS-1:0]   layer_fade,
  output logic [19*N_LAYERS-1:0]  rom_addr,
  input  logic [24*N_LAYERS-1:0]  rom_data,
  input  logic [N_LAYERS-1:0]     kill,
  input  logic                    game_over,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic [1:0]              state,
  output logic [2:0]              anim_idx
);
  typedef enum logic [1:0] {PLAY = 2'd0, DYING = 2'd1, OVER = 2'd2} state_t;

  localparam logic [7:0] LAST_SUB  = 8'(ANIM_PERIOD - 1);
  localparam logic [2:0] LAST_ANIM = 3'(ANIM_STEPS - 1);

  state_t              st;
  logic [N_LAYERS-1:0] dead_mask;
  logic [7:0]          sub_cnt;
  logic                fclk_q, fclk_qq, tick;

  assign tick  = fclk_q & ~fclk_qq;
  assign state = st;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fclk_q  <= 1'b0;
      fclk_qq <= 1'b0;
    end else begin
      fclk_q  <= frame_clk;
      fclk_qq <= fclk_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st        <= PLAY;
      dead_mask <= '0;
      anim_idx  <= '0;
      sub_cnt   <= '0;
    end else if (game_over) begin
      st        <= OVER;
      dead_mask <= dead_mask | kill;
    end else begin
      case (st)
        PLAY: if (|kill) begin
          dead_mask <= dead_mask | kill;
          st        <= DYING;
          anim_idx  <= '0;
          sub_cnt   <= '0;
        end
        DYING: begin
          dead_mask <= dead_mask | kill;
          if (tick) begin
            if (sub_cnt == LAST_SUB) begin
              sub_cnt <= '0;
              // The final frame is held when the animation ends.
              if (anim_idx == LAST_ANIM) st <= OVER;
              else                       anim_idx <= anim_idx + 3'd1;
            end else begin
              sub_cnt <= sub_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
    sprite_layer u_layer (
      .clk    (Clk),
      .reset  (Reset),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .org_x  (layer_x[10*i +: 10]),
      .org_y  (layer_y[10*i +: 10]),
      .shift  (layer_shift[3*i +: 3]),
      .frame  (dead_mask[i] ? anim_idx : 3'd0),
      .addr   (rom_addr[19*i +: 19])
    );
  end

  // Side-band info travels alongside the ROM access so it meets rom_data.
  logic [ROM_LAT:0]                 vld_pipe;
  logic [ROM_LAT:0][N_LAYERS-1:0]   hit_pipe, dead_pipe;
  logic [ROM_LAT:0][2*N_LAYERS-1:0] fade_pipe;
  logic [ROM_LAT:0][1:0]            st_pipe;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe  <= '0;
      hit_pipe  <= '0;
      dead_pipe <= '0;
      fade_pipe <= '0;
      st_pipe   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[ROM_LAT-1:0], 1'b1};
      hit_pipe  <= {hit_pipe[ROM_LAT-1:0], layer_hit};
      dead_pipe <= {dead_pipe[ROM_LAT-1:0], dead_mask};
      fade_pipe <= {fade_pipe[ROM_LAT-1:0], layer_fade};
      st_pipe   <= {st_pipe[ROM_LAT-1:0], st};
    end
  end

  function automatic logic [23:0] fade_px(input logic [23:0] c, input logic [1:0] f);
    logic [9:0]  s;
    logic [23:0] o;
    o = '0;
    for (int k = 0; k < 3; k++) begin
      s = {2'b00, c[8*k +: 8]} + 10'(f) * 10'd50;
      o[8*k +: 8] = (s > 10'd255) ? 8'hFF : s[7:0];
    end
    return o;
  endfunction

  logic [N_LAYERS-1:0]   hit_d, dead_d;
  logic [2*N_LAYERS-1:0] fade_d;
  state_t                st_d;
  logic [23:0]           pix, d;
  logic                  found;

  assign hit_d  = hit_pipe[ROM_LAT];
  assign dead_d = dead_pipe[ROM_LAT];
  assign fade_d = fade_pipe[ROM_LAT];
  assign st_d   = state_t'(st_pipe[ROM_LAT]);

  always_comb begin
    pix   = BG;
    found = 1'b0;
    d     = '0;
    if (vld_pipe[ROM_LAT]) begin
      if (st_d == OVER) begin
        pix = 24'h000000;
        if (hit_d[0] && rom_data[23:0] != KEY) pix = rom_data[23:0];
      end else begin
        for (int i = 0; i < N_LAYERS; i++) begin
          d = rom_data[24*i +: 24];
          if (!found && hit_d[i] && d != KEY && (!dead_d[i] || st_d == DYING)) begin
            found = 1'b1;
            pix   = fade_px(d, fade_d[2*i +: 2]);
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) {VGA_R, VGA_G, VGA_B} <= '0;
    else       {VGA_R, VGA_G, VGA_B} <= pix;
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed vectors plus randomized traffic against
// a cycle model built from the compositing and animation rules.

module tb_sprite_compositor;
  localparam int N = 4, RL = 2, S = 5, P = 5;
  localparam logic [23:0] KEY = 24'hFF0000, BG = 24'hB7FE7B;

  logic           Clk = 1'b0;
  logic           Reset, frame_clk, game_over;
  logic [9:0]     DrawX, DrawY;
  logic [N-1:0]   layer_hit, kill;
  logic [10*N-1:0] layer_x, layer_y;
  logic [3*N-1:0] layer_shift;
  logic [2*N-1:0] layer_fade;
  logic [19*N-1:0] rom_addr;
  logic [24*N-1:0] rom_data;
  logic [7:0]     VGA_R, VGA_G, VGA_B;
  logic [1:0]     state;
  logic [2:0]     anim_idx;

  sprite_compositor #(
    .N_LAYERS(N), .ROM_LAT(RL), .KEY(KEY), .BG(BG), .ANIM_STEPS(S), .ANIM_PERIOD(P)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .layer_hit(layer_hit), .layer_x(layer_x), .layer_y(layer_y),
    .layer_shift(layer_shift), .layer_fade(layer_fade), .rom_addr(rom_addr),
    .rom_data(rom_data), .kill(kill), .game_over(game_over),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .state(state), .anim_idx(anim_idx)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0;
  bit vga_chk = 1'b1;
  bit force_en = 1'b0;
  logic [23:0] frc [N];

  function automatic logic [23:0] rom_fn(input int i, input logic [18:0] a);
    logic [31:0] h;
    h = (32'(a) + 32'(i) * 32'h9E37) * 32'h045D9F3B;
    h = h ^ (h >> 15);
    if (h[3:2] == 2'b00) return KEY;
    return h[27:4];
  endfunction

  // External ROM: data for an address shows up RL cycles later.
  logic [19*N-1:0] rq [RL];
  always @(posedge Clk) begin
    rq[0] <= rom_addr;
    for (int k = 1; k < RL; k++) rq[k] <= rq[k-1];
  end
  always_comb begin
    rom_data = '0;
    for (int i = 0; i < N; i++)
      rom_data[24*i +: 24] = force_en ? frc[i] : rom_fn(i, rq[RL-1][19*i +: 19]);
  end

  // Reference model: death progress is a plain count of ticks since the kill.
  bit          m_dying, m_over, s1, s2;
  int          m_ticks;
  logic [N-1:0] m_dead;
  logic [23:0] e_vga;
  logic [18:0] e_addr [N];
  logic [23:0] pend [$];

  function automatic int m_st();
    return m_over ? 2 : (m_dying ? 1 : 0);
  endfunction
  function automatic int m_an();
    int a = m_ticks / P;
    return (a > S - 1) ? S - 1 : a;
  endfunction
  function automatic logic [23:0] fadep(input logic [23:0] c, input int f);
    logic [23:0] o;
    int v;
    o = '0;
    for (int k = 0; k < 3; k++) begin
      v = int'(c[8*k +: 8]) + 50 * f;
      if (v > 255) v = 255;
      o[8*k +: 8] = 8'(v);
    end
    return o;
  endfunction

  task automatic model_edge();
    int st, an, dx, dy, sh, loc, a;
    logic [23:0] d [N];
    logic [23:0] px;
    bit tick, done;
    if (Reset) begin
      m_dying = 0; m_over = 0; m_ticks = 0; m_dead = '0; s1 = 0; s2 = 0;
      e_vga = 24'h0;
      for (int i = 0; i < N; i++) e_addr[i] = '0;
      pend.delete();
      for (int k = 0; k <= RL; k++) pend.push_back(BG);
    end else begin
      st = m_st();
      an = m_an();
      for (int i = 0; i < N; i++) begin
        dx = (int'(DrawX) - int'(layer_x[10*i +: 10])) & 1023;
        dy = (int'(DrawY) - int'(layer_y[10*i +: 10])) & 1023;
        sh = int'(layer_shift[3*i +: 3]);
        if (sh > 6) sh = 6;
        loc = (dx + (dy << sh)) & 32'hFFFF;
        a = (m_dead[i] ? an : 0) * 65536 + loc;
        e_addr[i] = 19'(a);
        d[i] = force_en ? frc[i] : rom_fn(i, 19'(a));
      end
      px = BG;
      done = 0;
      if (st == 2) px = (layer_hit[0] && d[0] != KEY) ? d[0] : 24'h0;
      else
        for (int i = 0; i < N; i++)
          if (!done && layer_hit[i] && d[i] != KEY && (!m_dead[i] || st == 1)) begin
            done = 1;
            px = fadep(d[i], int'(layer_fade[2*i +: 2]));
          end
      pend.push_back(px);
      e_vga = pend.pop_front();
      tick = s1 && !s2;
      if (game_over) begin
        m_over = 1;
        m_dead = m_dead | kill;
      end else if (!m_over && !m_dying) begin
        if (|kill) begin m_dying = 1; m_ticks = 0; m_dead = m_dead | kill; end
      end else if (!m_over) begin
        m_dead = m_dead | kill;
        if (tick) begin
          m_ticks++;
          if (m_ticks == S * P) m_over = 1;
        end
      end
      s2 = s1;
      s1 = frame_clk;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    chk("state", 32'(state), m_st());
    chk("anim_idx", 32'(anim_idx), m_an());
    for (int i = 0; i < N; i++)
      chk($sformatf("rom_addr%0d", i), 32'(rom_addr[19*i +: 19]), 32'(e_addr[i]));
    if (vga_chk) chk("vga_model", {8'h0, VGA_R, VGA_G, VGA_B}, 32'(e_vga));
  endtask

  task automatic do_reset();
    Reset = 1; kill = '0; game_over = 0; frame_clk = 0;
    cyc(); cyc();
    Reset = 0;
  endtask

  task automatic pulse();
    frame_clk = 1; cyc(); cyc();
    frame_clk = 0; cyc(); cyc();
  endtask

  task automatic rand_inputs();
    DrawX = 10'($urandom); DrawY = 10'($urandom);
    layer_x = {N{10'd0}}; layer_y = {N{10'd0}};
    for (int i = 0; i < N; i++) begin
      layer_x[10*i +: 10] = 10'($urandom);
      layer_y[10*i +: 10] = 10'($urandom);
      layer_shift[3*i +: 3] = 3'($urandom_range(0, 7));
    end
    layer_hit = N'($urandom);
    layer_fade = (2*N)'($urandom);
  endtask

  function automatic logic [23:0] vga();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  typedef struct {
    logic [N-1:0]   hit;
    logic [2*N-1:0] fade;
    logic [23:0]    d0, d1, d2, d3;
    logic [23:0]    exp;
    string          name;
  } vec_t;
  vec_t tbl [8];

  logic [23:0] exp23;

  initial begin
    tbl[0] = '{4'b0101, 8'h10, KEY, 24'h0, 24'h123456, 24'h0, 24'h446688, "key_fallthru_fade"};
    tbl[1] = '{4'b0101, 8'h10, 24'h000001, 24'h0, 24'h123456, 24'h0, 24'h000001, "layer0_wins"};
    tbl[2] = '{4'b0000, 8'hFF, 24'h111111, 24'h222222, 24'h333333, 24'h444444, BG, "no_hit_bg"};
    tbl[3] = '{4'b1111, 8'h00, KEY, KEY, KEY, KEY, BG, "all_key_bg"};
    tbl[4] = '{4'b0010, 8'h0C, 24'h0, 24'hD0D0D0, 24'h0, 24'h0, 24'hFFFFFF, "fade3_saturate"};
    tbl[5] = '{4'b1000, 8'h80, 24'h0, 24'h0, 24'h0, 24'h102030, 24'h748494, "fade2_layer3"};
    tbl[6] = '{4'b1100, 8'h40, 24'h0, 24'h0, KEY, 24'h0000FF, 24'h3232FF, "fade1_blue_sat"};
    tbl[7] = '{4'b0001, 8'h01, 24'hFF0001, 24'h0, 24'h0, 24'h0, 24'hFF3233, "near_key_opaque"};

    DrawX = 0; DrawY = 0; layer_hit = '0; layer_x = '0; layer_y = '0;
    layer_shift = '0; layer_fade = '0;
    for (int i = 0; i < N; i++) frc[i] = '0;
    do_reset();

    // Address arithmetic, post-reset background and end-to-end latency.
    layer_x[10 +: 10] = 10'd100; layer_y[10 +: 10] = 10'd50; layer_shift[3 +: 3] = 3'd5;
    layer_hit = 4'b0010; DrawX = 10'd103; DrawY = 10'd52;
    cyc();
    chk("bg_after_reset", 32'(vga()), 32'(BG));
    chk("addr_layer1", 32'(rom_addr[19 +: 19]), 32'd67);
    DrawX = 0; DrawY = 0; layer_hit = '0;
    for (int k = 0; k < RL; k++) begin
      cyc();
      chk("bg_after_reset", 32'(vga()), 32'(BG));
    end
    cyc();
    exp23 = (rom_fn(1, 19'd67) == KEY) ? BG : rom_fn(1, 19'd67);
    chk("layer1_latency", 32'(vga()), 32'(exp23));

    // Priority / key / fade vectors with fixed ROM data.
    do_reset();
    vga_chk = 0; force_en = 1;
    foreach (tbl[v]) begin
      frc[0] = tbl[v].d0; frc[1] = tbl[v].d1; frc[2] = tbl[v].d2; frc[3] = tbl[v].d3;
      layer_hit = tbl[v].hit; layer_fade = tbl[v].fade;
      repeat (RL + 2) cyc();
      chk(tbl[v].name, 32'(vga()), 32'(tbl[v].exp));
    end

    // game_over together with kill[0]: OVER wins, only opaque layer 0 drawn.
    do_reset();
    frc[0] = KEY; frc[1] = 24'h112233; layer_hit = 4'b0011; layer_fade = '0;
    game_over = 1; kill = 4'b0001;
    cyc();
    chk("over_next_cycle", 32'(state), 32'd2);
    game_over = 0; kill = '0;
    repeat (RL + 2) cyc();
    chk("over_black", 32'(vga()), 32'h0);
    frc[0] = 24'h00AA00; layer_fade = 8'hFF;
    repeat (RL + 2) cyc();
    chk("over_layer0_unfaded", 32'(vga()), 32'h00AA00);
    layer_hit = 4'b0010;
    repeat (RL + 2) cyc();
    chk("over_black_l1", 32'(vga()), 32'h0);
    force_en = 0;

    // Full death animation of layer 2.
    do_reset();
    vga_chk = 1;
    rand_inputs();
    kill = 4'b0100; cyc(); kill = '0;
    for (int k = 1; k <= S * P; k++) begin
      pulse();
      chk("death_anim", 32'(anim_idx), (k / P > S - 1) ? S - 1 : k / P);
      chk("death_state", 32'(state), (k == S * P) ? 2 : 1);
      chk("death_addr_frame", 32'(rom_addr[19*2 + 16 +: 3]), 32'(anim_idx));
    end

    // A level held high is a single tick.
    do_reset();
    kill = 4'b0010; cyc(); kill = '0;
    frame_clk = 1;
    repeat (1000) cyc();
    frame_clk = 0; cyc(); cyc();
    chk("held_high_state", 32'(state), 32'd1);
    chk("held_high_anim", 32'(anim_idx), 32'd0);
    repeat (P - 2) pulse();
    chk("held_high_anim_later", 32'(anim_idx), 32'd0);
    pulse();
    chk("one_tick_total", 32'(anim_idx), 32'd1);

    // Reset coincident with a tick at anim_idx 3.
    do_reset();
    kill = 4'b1000; cyc(); kill = '0;
    repeat (3 * P) pulse();
    chk("pre_reset_anim", 32'(anim_idx), 32'd3);
    frame_clk = 1; cyc();
    Reset = 1; cyc();
    chk("reset_tick_state", 32'(state), 32'd0);
    chk("reset_tick_anim", 32'(anim_idx), 32'd0);
    chk("reset_tick_vga", 32'(vga()), 32'h0);
    Reset = 0; frame_clk = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      Reset = ($urandom_range(0, 249) == 0);
      kill = ($urandom_range(0, 59) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      game_over = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
